pattern_generator: RTL and testbench

- Parametrised AXI-Stream test-pattern source for QSFP link-integrity testing.
- Emits fixed-length packets of lane-replicated counter data at full line rate.
- Supports two pattern modes and a one-shot, debounce-free single-bit error injector.
- Sits at the TX side of the link, ahead of the CMAC/aurora stream input; the RX-side checker reproduces the same pattern.

---
 rtl/pattern_gen_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 28 ++
 rtl/pattern_generator.sv | 136 +++++++++++++
 tb/tb_pattern_generator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and the lane pattern function for the link-integrity pattern source.
// The RX-side checker uses the same function to rebuild the expected data.
package pattern_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_REPLICATE   = 1'b0;
  localparam logic MODE_LANE_OFFSET = 1'b1;

  // Lane widths up to this many bits are supported; callers truncate to LANE_WIDTH.
  localparam int PAT_MAX_W = 32;

  function automatic logic [PAT_MAX_W-1:0] lane_pattern(
    input logic [PAT_MAX_W-1:0] counter,
    input logic [PAT_MAX_W-1:0] lane,
    input logic                 mode
  );
    return (mode == MODE_LANE_OFFSET) ? counter + lane : counter;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// rising-edge pulse in the clock domain.
module sync_edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic async_in,
  output logic pulse
);

  logic meta_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~hist_p2;

endmodule

// File: rtl/pattern_generator.sv
// AXI-Stream test-pattern source: fixed-length packets of lane-replicated counter
// data at one beat per clock, with a one-shot single-bit error injector.
module pattern_generator #(
  parameter int DATA_WIDTH   = 256,
  parameter int LANE_WIDTH   = 16,
  parameter int PACKET_BEATS = 64,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   inject_error,
  output logic [DATA_WIDTH-1:0]  AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY,
  output logic [COUNT_WIDTH-1:0] packets_sent,
  output logic [COUNT_WIDTH-1:0] errors_injected,
  output logic                   busy
);

  import pattern_gen_pkg::*;

  localparam int LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int BEAT_W = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_BEATS - 1);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic inject_pulse;

  sync_edge_detect u_inject_sync (
    .clock    (clock),
    .resetn   (rst_n_int),
    .async_in (inject_error),
    .pulse    (inject_pulse)
  );

  state_t                  state_q, state_d;
  logic [LANE_WIDTH-1:0]   counter_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    pending_q;
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   tdata_p0;
  logic                    vld_p0;
  logic                    tlast_p0;
  logic                    corrupt_p0;
  logic [COUNT_WIDTH-1:0]  packets_q;
  logic [COUNT_WIDTH-1:0]  errors_q;

  logic                    hs;
  logic                    exit_run;
  logic                    load;
  logic                    pkt_mode;
  logic [DATA_WIDTH-1:0]   pattern;

  always_comb begin
    hs       = vld_p0 & AXIS_TREADY;
    exit_run = (state_q == RUN) && hs && tlast_p0 && !enable;
    load     = ((state_q == IDLE) && enable) ||
               ((state_q == RUN) && (!vld_p0 || AXIS_TREADY) && !exit_run);

    state_d = state_q;
    if ((state_q == IDLE) && enable) state_d = RUN;
    else if (exit_run)               state_d = IDLE;

    // Mode is only picked up at the start of a packet.
    pkt_mode = (beat_q == '0) ? mode : mode_q;

    pattern = '0;
    for (int i = 0; i < LANES; i++) begin
      pattern[i*LANE_WIDTH +: LANE_WIDTH] =
        LANE_WIDTH'(lane_pattern(PAT_MAX_W'(counter_q), PAT_MAX_W'(i), pkt_mode));
    end
    pattern[0] = pattern[0] ^ pending_q;
  end

  // Output stage: beat load, handshake tracking, statistics
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      beat_q     <= '0;
      pending_q  <= 1'b0;
      mode_q     <= MODE_REPLICATE;
      tdata_p0   <= '0;
      vld_p0     <= 1'b0;
      tlast_p0   <= 1'b0;
      corrupt_p0 <= 1'b0;
      packets_q  <= '0;
      errors_q   <= '0;
    end else begin
      state_q <= state_d;

      if (load) begin
        tdata_p0   <= pattern;
        tlast_p0   <= (beat_q == LAST_BEAT);
        corrupt_p0 <= pending_q;
        mode_q     <= pkt_mode;
        counter_q  <= counter_q + 1'b1;
        beat_q     <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end

      if (load)    vld_p0 <= 1'b1;
      else if (hs) vld_p0 <= 1'b0;

      // An edge landing on a load cycle (or while already pending) cannot stack a second flip.
      pending_q <= load ? (inject_pulse & ~pending_q) : (pending_q | inject_pulse);

      if (hs && tlast_p0)   packets_q <= sat_inc(packets_q);
      if (hs && corrupt_p0) errors_q  <= sat_inc(errors_q);
    end
  end

  assign AXIS_TDATA      = tdata_p0;
  assign AXIS_TVALID     = vld_p0;
  assign AXIS_TLAST      = tlast_p0;
  assign packets_sent    = packets_q;
  assign errors_injected = errors_q;
  assign busy            = (state_q == RUN);

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator with PACKET_BEATS=4.
module tb_pattern_generator;

  localparam int DW = 256;
  localparam int LW = 16;
  localparam int PB = 4;
  localparam int CW = 32;
  localparam int LANES = DW / LW;

  logic          clock = 1'b0;
  logic          resetn;
  logic          enable;
  logic          mode;
  logic          inject_error;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [CW-1:0] packets_sent;
  logic [CW-1:0] errors_injected;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;
  int          exp_beat;

  always #5 clock = ~clock;

  pattern_generator #(
    .DATA_WIDTH   (DW),
    .LANE_WIDTH   (LW),
    .PACKET_BEATS (PB),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .mode            (mode),
    .inject_error    (inject_error),
    .AXIS_TDATA      (tdata),
    .AXIS_TVALID     (tvalid),
    .AXIS_TLAST      (tlast),
    .AXIS_TREADY     (tready),
    .packets_sent    (packets_sent),
    .errors_injected (errors_injected),
    .busy            (busy)
  );

  function automatic logic [DW-1:0] pat(input logic [15:0] c, input logic m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*LW +: LW] = m ? c + 16'(i) : c;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    resetn = 1'b0; enable = 1'b0; mode = 1'b0; inject_error = 1'b0; tready = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    exp_cnt = 16'h0; exp_beat = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; mode = 1'b0; inject_error = 1'b0; tready = 1'b0;
    @(negedge clock);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
    checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
    checks++; if (packets_sent !== '0) begin errors++; $display("FAIL reset_packets got %0d want 0", packets_sent); end
    checks++; if (errors_injected !== '0) begin errors++; $display("FAIL reset_errors got %0d want 0", errors_injected); end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %b want 0", tvalid); end
  endtask

  task automatic test_basic();
    apply_reset();
    mode = 1'b0; tready = 1'b1; enable = 1'b1;
    @(negedge clock);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", tvalid); end
    for (int b = 0; b < PB; b++) begin
      checks++;
      if (tdata !== pat(16'(b), 1'b0)) begin errors++; $display("FAIL basic_data beat %0d got %h want %h", b, tdata, pat(16'(b), 1'b0)); end
      checks++;
      if (tlast !== (b == PB-1)) begin errors++; $display("FAIL basic_tlast beat %0d got %b want %b", b, tlast, (b == PB-1)); end
      @(negedge clock);
    end
    checks++; if (packets_sent !== 32'd1) begin errors++; $display("FAIL basic_packets got %0d want 1", packets_sent); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
  endtask

  task automatic test_lane_offset();
    apply_reset();
    mode = 1'b1; tready = 1'b1; enable = 1'b1;
    @(negedge clock);
    checks++; if (tdata !== pat(16'h0, 1'b1)) begin errors++; $display("FAIL offset_beat0 got %h want %h", tdata, pat(16'h0, 1'b1)); end
    @(negedge clock);
    checks++; if (tdata !== pat(16'h1, 1'b1)) begin errors++; $display("FAIL offset_beat1 got %h want %h", tdata, pat(16'h1, 1'b1)); end
    exp_cnt = 16'h1; exp_beat = 1;
  endtask

  task automatic test_backpressure();
    logic          prev_hold;
    logic [DW-1:0] held_data;
    logic          held_last;
    prev_hold = 1'b0; held_data = '0; held_last = 1'b0;
    mode = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc %0d got %b want 1", cyc, tvalid); end
      if (prev_hold) begin
        checks++; if (tdata !== held_data) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h want %h", cyc, tdata, held_data); end
        checks++; if (tlast !== held_last) begin errors++; $display("FAIL bp_hold_last cyc %0d got %b want %b", cyc, tlast, held_last); end
      end
      checks++; if (tdata[15:0] !== exp_cnt) begin errors++; $display("FAIL bp_lane0 cyc %0d got %h want %h", cyc, tdata[15:0], exp_cnt); end
      checks++; if (tlast !== (exp_beat == PB-1)) begin errors++; $display("FAIL bp_tlast cyc %0d got %b want %b", cyc, tlast, (exp_beat == PB-1)); end
      tready = 1'($urandom_range(0, 1));
      if (tvalid && tready) begin exp_cnt = exp_cnt + 16'h1; exp_beat = (exp_beat + 1) % PB; end
      prev_hold = tvalid && !tready;
      held_data = tdata;
      held_last = tlast;
      @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    int guard;
    int phase;
    int total;
    guard = 0; phase = 0;
    mode = 1'b1; tready = 1'b1;
    while (phase < 3 && guard < 70000) begin
      guard++;
      if (tvalid) begin
        if (exp_cnt == 16'hFFFE && phase == 0) begin
          checks++; if (tdata !== pat(16'hFFFE, 1'b1)) begin errors++; $display("FAIL wrap_fffe_beat got %h want %h", tdata, pat(16'hFFFE, 1'b1)); end
          checks++; if (tdata[15*LW +: LW] !== 16'h000D) begin errors++; $display("FAIL wrap_lane15 got %h want 000d", tdata[15*LW +: LW]); end
          checks++; if (tdata[15:0] !== 16'hFFFE) begin errors++; $display("FAIL wrap_lane0_fffe got %h want fffe", tdata[15:0]); end
          phase = 1;
        end else if (exp_cnt == 16'hFFFF && phase == 1) begin
          checks++; if (tdata[15:0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_lane0_ffff got %h want ffff", tdata[15:0]); end
          phase = 2;
        end else if (exp_cnt == 16'h0000 && phase == 2) begin
          checks++; if (tdata[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_lane0_0000 got %h want 0000", tdata[15:0]); end
          phase = 3;
        end
        exp_cnt = exp_cnt + 16'h1;
        exp_beat = (exp_beat + 1) % PB;
      end
      @(negedge clock);
    end
    checks++; if (phase != 3) begin errors++; $display("FAIL wrap_timeout phase got %0d want 3", phase); end
    total = 65536 + int'(exp_cnt);
    checks++; if (packets_sent !== CW'(total / PB)) begin errors++; $display("FAIL wrap_packets got %0d want %0d", packets_sent, total / PB); end
  endtask

  task automatic test_inject();
    checks++; if (errors_injected !== '0) begin errors++; $display("FAIL inj_pre_count got %0d want 0", errors_injected); end
    tready = 1'b0;
    @(negedge clock); inject_error = 1'b1;
    @(negedge clock); inject_error = 1'b0;
    @(negedge clock); inject_error = 1'b1;
    @(negedge clock); inject_error = 1'b0;
    repeat (6) @(negedge clock);
    tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (tdata[15:0] !== (exp_cnt ^ ((k == 1) ? 16'h1 : 16'h0)))
        begin errors++; $display("FAIL inj_lane0 k %0d got %h want %h", k, tdata[15:0], exp_cnt ^ ((k == 1) ? 16'h1 : 16'h0)); end
      exp_cnt = exp_cnt + 16'h1;
      exp_beat = (exp_beat + 1) % PB;
      @(negedge clock);
    end
    checks++; if (errors_injected !== 32'd1) begin errors++; $display("FAIL inj_count got %0d want 1", errors_injected); end
  endtask

  task automatic test_idle_inject();
    apply_reset();
    @(negedge clock); inject_error = 1'b1;
    @(negedge clock); inject_error = 1'b0;
    repeat (5) @(negedge clock);
    mode = 1'b0; tready = 1'b1; enable = 1'b1;
    @(negedge clock);
    checks++; if (tdata[15:0] !== 16'h0001) begin errors++; $display("FAIL idle_inj_beat0 got %h want 0001", tdata[15:0]); end
    @(negedge clock);
    checks++; if (tdata[15:0] !== 16'h0001) begin errors++; $display("FAIL idle_inj_beat1 got %h want 0001", tdata[15:0]); end
    checks++; if (errors_injected !== 32'd1) begin errors++; $display("FAIL idle_inj_count got %0d want 1", errors_injected); end
  endtask

  task automatic test_stop_and_abort();
    apply_reset();
    mode = 1'b0; tready = 1'b1; enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (tdata[15:0] !== 16'h0001) begin errors++; $display("FAIL stop_beat1 got %h want 0001", tdata[15:0]); end
    enable = 1'b0;
    @(negedge clock);
    checks++; if (tvalid !== 1'b1 || tdata[15:0] !== 16'h0002 || tlast !== 1'b0)
      begin errors++; $display("FAIL stop_beat2 got v%b d%h l%b want v1 d0002 l0", tvalid, tdata[15:0], tlast); end
    @(negedge clock);
    checks++; if (tvalid !== 1'b1 || tdata[15:0] !== 16'h0003 || tlast !== 1'b1)
      begin errors++; $display("FAIL stop_beat3 got v%b d%h l%b want v1 d0003 l1", tvalid, tdata[15:0], tlast); end
    @(negedge clock);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stop_tvalid got %b want 0", tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
    checks++; if (packets_sent !== 32'd1) begin errors++; $display("FAIL stop_packets got %0d want 1", packets_sent); end
    @(negedge clock);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stop_stays_idle got %b want 0", tvalid); end
    enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (tvalid !== 1'b1 || tdata[15:0] !== 16'h0005)
      begin errors++; $display("FAIL abort_pre got v%b d%h want v1 d0005", tvalid, tdata[15:0]); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid got %b want 0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL abort_tlast got %b want 0", tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (packets_sent !== '0) begin errors++; $display("FAIL abort_packets got %0d want 0", packets_sent); end
    enable = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (tvalid !== 1'b0 || tlast !== 1'b0)
      begin errors++; $display("FAIL abort_after got v%b l%b want v0 l0", tvalid, tlast); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lane_offset();
    test_backpressure();
    test_wrap();
    test_inject();
    test_idle_inject();
    test_stop_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
